// File: rtl/parity_check_stream.sv
// ---------------------------------------------------------------------------
// parity_check_stream
//
// Receive-side parity checker for a valid/ready stream. Each accepted word is
// checked against its transmitted parity bit, then forwarded one cycle later
// from a single-entry output register together with an error flag. A
// saturating error counter and a sticky error flag are kept for status
// readout, with a one-cycle strobe for every failing word accepted.
//
// Parameters
//   WIDTH      data bits per word (>= 1)
//   ODD        expected value of ^{in_data, in_parity}; 0 pairs with a
//              generator that computes parity = ^data
//   CNT_WIDTH  error counter width (>= 1)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_valid    input word present
//   in_ready    block can take the input word this cycle
//   in_data     input data word
//   in_parity   transmitted parity bit
//   out_valid   output word present
//   out_ready   downstream accepts the output word
//   out_data    registered copy of the accepted word
//   out_err     accepted word failed the parity check
//   err_pulse   one-cycle strobe after a failing word is accepted
//   err_cnt     saturating count of failing words accepted
//   err_sticky  set by any failing word, held until clr_err
//   clr_err     synchronous clear of err_cnt and err_sticky
// ---------------------------------------------------------------------------
module parity_check_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ODD       = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  localparam logic                 ODD_BIT = (ODD != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic accept;
  logic bad;
  logic bad_accept;

  // The output register can take a new word when empty or when its current
  // word leaves this same cycle, giving one word per cycle under no stall.
  // Reset forces it low so nothing is consumed during the reset cycle.
  assign in_ready   = !rst && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign bad        = ((^{in_data, in_parity}) != ODD_BIT);
  assign bad_accept = accept && bad;

  // Data path: one-entry output register. EMPTY/FULL is out_valid itself.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_err   <= bad;
    end else if (out_valid && out_ready) begin
      // Drained with nothing behind it; data/err hold as don't-care.
      out_valid <= 1'b0;
    end
  end

  // Status: a failing accept takes priority over clr_err, so a coincident
  // clear restarts the count at one instead of losing the new error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse <= bad_accept;
      if (bad_accept) begin
        err_sticky <= 1'b1;
        if (clr_err) begin
          err_cnt <= CNT_ONE;
        end else if (!(&err_cnt)) begin
          err_cnt <= err_cnt + CNT_ONE;
        end
      end else if (clr_err) begin
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_check_stream.sv
// ---------------------------------------------------------------------------
// tb_parity_check_stream
//
// Three instances share one stimulus stream:
//   dut_a  WIDTH=8, ODD=0, CNT_WIDTH=16  (main instance)
//   dut_b  WIDTH=8, ODD=0, CNT_WIDTH=2   (counter saturation)
//   dut_c  WIDTH=8, ODD=1, CNT_WIDTH=16  (inverted parity sense)
// A negedge monitor keeps a reference model: words are pushed to a queue on
// accept and popped/compared when they drain; status outputs are compared
// against modelled values every cycle. Scenario tasks add their own checks.
// ---------------------------------------------------------------------------
module tb_parity_check_stream;

  typedef struct {
    logic [7:0] data;
    logic       err_a;
    logic       err_c;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_parity;
  logic        out_ready;
  logic        clr_err;

  logic        in_ready_a, out_valid_a, out_err_a, err_pulse_a, err_sticky_a;
  logic [7:0]  out_data_a;
  logic [15:0] err_cnt_a;
  logic        in_ready_b, out_valid_b, out_err_b, err_pulse_b, err_sticky_b;
  logic [7:0]  out_data_b;
  logic [1:0]  err_cnt_b;
  logic        in_ready_c, out_valid_c, out_err_c, err_pulse_c, err_sticky_c;
  logic [7:0]  out_data_c;
  logic [15:0] err_cnt_c;

  int n_total = 0;
  int n_bad   = 0;
  bit mon_en  = 1'b0;

  sb_t         sb[$];
  logic        m_pulse_a = 1'b0, m_sticky_a = 1'b0;
  logic        m_pulse_c = 1'b0, m_sticky_c = 1'b0;
  logic [15:0] m_cnt_a = '0, m_cnt_c = '0;
  logic [1:0]  m_cnt_b = '0;

  always #5 clk = ~clk;

  parity_check_stream #(.WIDTH(8), .ODD(0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_err(out_err_a),
    .err_pulse(err_pulse_a), .err_cnt(err_cnt_a), .err_sticky(err_sticky_a),
    .clr_err(clr_err)
  );

  parity_check_stream #(.WIDTH(8), .ODD(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_err(out_err_b),
    .err_pulse(err_pulse_b), .err_cnt(err_cnt_b), .err_sticky(err_sticky_b),
    .clr_err(clr_err)
  );

  parity_check_stream #(.WIDTH(8), .ODD(1), .CNT_WIDTH(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_data(out_data_c), .out_err(out_err_c),
    .err_pulse(err_pulse_c), .err_cnt(err_cnt_c), .err_sticky(err_sticky_c),
    .clr_err(clr_err)
  );

  // Reference model and scoreboard. Inputs change 2 time units after the
  // rising edge, so at the falling edge they are stable for the next edge.
  always @(negedge clk) begin
    logic exp_ready, acc, pa, pc;
    if (mon_en) begin
      exp_ready = !rst && (sb.size() == 0 || out_ready);
      n_total++; if (in_ready_a !== exp_ready) begin n_bad++; $display("FAIL mon_in_ready_a: got %b want %b", in_ready_a, exp_ready); end
      n_total++; if (in_ready_b !== exp_ready) begin n_bad++; $display("FAIL mon_in_ready_b: got %b want %b", in_ready_b, exp_ready); end
      n_total++; if (in_ready_c !== exp_ready) begin n_bad++; $display("FAIL mon_in_ready_c: got %b want %b", in_ready_c, exp_ready); end
      n_total++; if (out_valid_a !== (sb.size() != 0)) begin n_bad++; $display("FAIL mon_out_valid_a: got %b want %b", out_valid_a, sb.size() != 0); end
      n_total++; if (out_valid_c !== (sb.size() != 0)) begin n_bad++; $display("FAIL mon_out_valid_c: got %b want %b", out_valid_c, sb.size() != 0); end
      if (sb.size() != 0) begin
        n_total++; if (out_data_a !== sb[0].data) begin n_bad++; $display("FAIL mon_out_data_a: got %h want %h", out_data_a, sb[0].data); end
        n_total++; if (out_data_b !== sb[0].data) begin n_bad++; $display("FAIL mon_out_data_b: got %h want %h", out_data_b, sb[0].data); end
        n_total++; if (out_err_a !== sb[0].err_a) begin n_bad++; $display("FAIL mon_out_err_a: got %b want %b", out_err_a, sb[0].err_a); end
        n_total++; if (out_err_c !== sb[0].err_c) begin n_bad++; $display("FAIL mon_out_err_c: got %b want %b", out_err_c, sb[0].err_c); end
        if (out_ready && !rst) void'(sb.pop_front());
      end
      n_total++; if (err_pulse_a !== m_pulse_a) begin n_bad++; $display("FAIL mon_err_pulse_a: got %b want %b", err_pulse_a, m_pulse_a); end
      n_total++; if (err_cnt_a !== m_cnt_a) begin n_bad++; $display("FAIL mon_err_cnt_a: got %0d want %0d", err_cnt_a, m_cnt_a); end
      n_total++; if (err_sticky_a !== m_sticky_a) begin n_bad++; $display("FAIL mon_err_sticky_a: got %b want %b", err_sticky_a, m_sticky_a); end
      n_total++; if (err_cnt_b !== m_cnt_b) begin n_bad++; $display("FAIL mon_err_cnt_b: got %0d want %0d", err_cnt_b, m_cnt_b); end
      n_total++; if (err_pulse_c !== m_pulse_c) begin n_bad++; $display("FAIL mon_err_pulse_c: got %b want %b", err_pulse_c, m_pulse_c); end
      n_total++; if (err_cnt_c !== m_cnt_c) begin n_bad++; $display("FAIL mon_err_cnt_c: got %0d want %0d", err_cnt_c, m_cnt_c); end
      n_total++; if (err_sticky_c !== m_sticky_c) begin n_bad++; $display("FAIL mon_err_sticky_c: got %b want %b", err_sticky_c, m_sticky_c); end
    end
    if (rst) begin
      sb.delete();
      m_pulse_a = 1'b0; m_sticky_a = 1'b0; m_cnt_a = '0; m_cnt_b = '0;
      m_pulse_c = 1'b0; m_sticky_c = 1'b0; m_cnt_c = '0;
    end else begin
      exp_ready = (sb.size() == 0) || out_ready;
      acc = in_valid && exp_ready;
      pa  = (^{in_data, in_parity}) != 1'b0;
      pc  = (^{in_data, in_parity}) != 1'b1;
      m_pulse_a = acc && pa;
      m_pulse_c = acc && pc;
      if (acc && pa) begin
        m_sticky_a = 1'b1;
        m_cnt_a = clr_err ? 16'd1 : (m_cnt_a == 16'hFFFF ? m_cnt_a : m_cnt_a + 16'd1);
        m_cnt_b = clr_err ? 2'd1 : (m_cnt_b == 2'd3 ? m_cnt_b : m_cnt_b + 2'd1);
      end else if (clr_err) begin
        m_sticky_a = 1'b0; m_cnt_a = '0; m_cnt_b = '0;
      end
      if (acc && pc) begin
        m_sticky_c = 1'b1;
        m_cnt_c = clr_err ? 16'd1 : (m_cnt_c == 16'hFFFF ? m_cnt_c : m_cnt_c + 16'd1);
      end else if (clr_err) begin
        m_sticky_c = 1'b0; m_cnt_c = '0;
      end
      if (acc) sb.push_back('{data: in_data, err_a: pa, err_c: pc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic p);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    n_total++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready_a); end
    n_total++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
    n_total++; if (out_data_a !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data_a); end
    n_total++; if (err_cnt_a !== 16'd0 || err_sticky_a !== 1'b0 || err_pulse_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_status: got cnt=%0d sticky=%b pulse=%b want 0/0/0", err_cnt_a, err_sticky_a, err_pulse_a);
    end
    rst = 1'b0;
    #1;
    n_total++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready_a); end
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] d[4] = '{8'h00, 8'hA5, 8'h01, 8'hFF};
    logic       p[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(d[i], p[i]);
      n_total++; if (out_valid_a !== 1'b1 || out_data_a !== d[i]) begin
        n_bad++; $display("FAIL stream_word%0d: got v=%b d=%h want v=1 d=%h", i, out_valid_a, out_data_a, d[i]);
      end
      n_total++; if (out_err_a !== 1'b0) begin n_bad++; $display("FAIL stream_err%0d: got %b want 0", i, out_err_a); end
    end
    idle();
    n_total++; if (err_cnt_a !== 16'd0 || err_sticky_a !== 1'b0) begin
      n_bad++; $display("FAIL stream_status: got cnt=%0d sticky=%b want 0/0", err_cnt_a, err_sticky_a);
    end
  endtask

  task automatic test_errors();
    logic [7:0] d[5] = '{8'h55, 8'h01, 8'h3C, 8'h03, 8'h0F};
    logic       p[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       e[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int pulses = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(d[i], p[i]);
      if (err_pulse_a === 1'b1) pulses++;
      n_total++; if (out_err_a !== e[i]) begin n_bad++; $display("FAIL errors_flag%0d: got %b want %b", i, out_err_a, e[i]); end
    end
    idle();
    if (err_pulse_a === 1'b1) pulses++;
    n_total++; if (pulses != 2) begin n_bad++; $display("FAIL errors_pulses: got %0d want 2", pulses); end
    n_total++; if (err_cnt_a !== 16'd2) begin n_bad++; $display("FAIL errors_cnt: got %0d want 2", err_cnt_a); end
    n_total++; if (err_sticky_a !== 1'b1) begin n_bad++; $display("FAIL errors_sticky: got %b want 1", err_sticky_a); end
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    cnt0 = err_cnt_a;
    out_ready = 1'b0;
    send(8'h96, 1'b0);
    in_data = 8'h69; in_parity = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready_a); end
      n_total++; if (out_valid_a !== 1'b1 || out_data_a !== 8'h96) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=96", i, out_valid_a, out_data_a);
      end
    end
    n_total++; if (err_cnt_a !== cnt0) begin n_bad++; $display("FAIL bp_cnt: got %0d want %0d", err_cnt_a, cnt0); end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++; if (out_valid_a !== 1'b1 || out_data_a !== 8'h69) begin
      n_bad++; $display("FAIL bp_release: got v=%b d=%h want v=1 d=69", out_valid_a, out_data_a);
    end
    tick();
    n_total++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid_a); end
  endtask

  task automatic test_clear();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_total++; if (err_cnt_a !== 16'd0 || err_sticky_a !== 1'b0 || err_cnt_b !== 2'd0) begin
      n_bad++; $display("FAIL clear_alone: got cnt_a=%0d sticky=%b cnt_b=%0d want 0/0/0", err_cnt_a, err_sticky_a, err_cnt_b);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_b[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(8'h01, 1'b0);
      n_total++; if (err_cnt_b !== exp_b[i]) begin n_bad++; $display("FAIL sat_cnt_b%0d: got %0d want %0d", i, err_cnt_b, exp_b[i]); end
      n_total++; if (err_cnt_a !== 16'(i + 1)) begin n_bad++; $display("FAIL sat_cnt_a%0d: got %0d want %0d", i, err_cnt_a, i + 1); end
    end
    idle();
  endtask

  task automatic test_clear_coincident();
    clr_err = 1'b1;
    send(8'h07, 1'b0);
    clr_err  = 1'b0;
    in_valid = 1'b0;
    n_total++; if (err_cnt_a !== 16'd1 || err_sticky_a !== 1'b1 || err_pulse_a !== 1'b1) begin
      n_bad++; $display("FAIL clear_coincident: got cnt=%0d sticky=%b pulse=%b want 1/1/1", err_cnt_a, err_sticky_a, err_pulse_a);
    end
    n_total++; if (err_cnt_b !== 2'd1) begin n_bad++; $display("FAIL clear_coincident_b: got %0d want 1", err_cnt_b); end
    tick();
  endtask

  task automatic test_odd();
    out_ready = 1'b1;
    send(8'h01, 1'b0);
    n_total++; if (out_err_c !== 1'b0 || out_err_a !== 1'b1) begin
      n_bad++; $display("FAIL odd_p0: got c=%b a=%b want c=0 a=1", out_err_c, out_err_a);
    end
    send(8'h01, 1'b1);
    n_total++; if (out_err_c !== 1'b1 || out_err_a !== 1'b0) begin
      n_bad++; $display("FAIL odd_p1: got c=%b a=%b want c=1 a=0", out_err_c, out_err_a);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(8'h01, 1'b0);
    n_total++; if (out_valid_a !== 1'b1 || err_sticky_a !== 1'b1) begin
      n_bad++; $display("FAIL rmid_full: got v=%b sticky=%b want 1/1", out_valid_a, err_sticky_a);
    end
    rst = 1'b1;
    in_data = 8'h22; in_parity = 1'b0;
    #1;
    n_total++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 0", in_ready_a); end
    tick();
    n_total++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid_a); end
    n_total++; if (err_cnt_a !== 16'd0 || err_sticky_a !== 1'b0 || err_pulse_a !== 1'b0) begin
      n_bad++; $display("FAIL rmid_status: got cnt=%0d sticky=%b pulse=%b want 0/0/0", err_cnt_a, err_sticky_a, err_pulse_a);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL rmid_release: got %b want 1", in_ready_a); end
    tick();
    n_total++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL rmid_no_accept: got %b want 0", out_valid_a); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_errors();
    test_backpressure();
    test_clear();
    test_saturation();
    test_clear_coincident();
    test_odd();
    test_reset_mid();
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/parity_check_stream.md
# parity_check_stream

Receive-side parity checker for valid/ready data streams: consumes data words with the parity bit computed by the team's parity generator (`parity = ^data`, XOR reduction), recomputes parity, and forwards each word one cycle later tagged with an error flag. It also keeps a saturating error counter and a sticky error flag for status/CSR readout. It sits at the sink of any parity-protected link or RAM read path, as the counterpart to the generator on the source side.

## Interface
- `WIDTH`, default 8: data bits per word, ≥1.
- `ODD`, default 0: expected value of `^{in_data, in_parity}`. Use 0 for the generator's `parity = ^data`, where the total count of 1s is even. Use 1 for an inverted generator.
- `CNT_WIDTH`, default 16: width of the error counter, ≥1.

- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input word present.
- `in_ready` out 1: block can accept the input word.
- `in_data` in WIDTH: data word.
- `in_parity` in 1: transmitted parity bit.
- `out_valid` out 1: output word present.
- `out_ready` in 1: downstream accepts.
- `out_data` out WIDTH: registered copy of the accepted `in_data`.
- `out_err` out 1: 1 if the word failed the parity check.
- `err_pulse` out 1: 1-cycle strobe on the cycle after a failing word is accepted.
- `err_cnt` out CNT_WIDTH: count of failing words accepted; saturates at all-ones.
- `err_sticky` out 1: set by any failing word; held until `clr_err`.
- `clr_err` in 1: synchronous clear of `err_cnt` and `err_sticky`.

## Operation
- Check: `bad = (^{in_data, in_parity}) != ODD`. This is evaluated on the input side and registered with the data.
- One-entry output register, implicit state EMPTY (`out_valid`=0) / FULL (`out_valid`=1).
- `in_ready = !rst && (!out_valid || out_ready)`. This is combinational and gives full throughput: a new word is accepted in the same cycle the held word drains.
- Accept = `in_valid && in_ready`. On accept: `out_data<=in_data`, `out_err<=bad`, `out_valid<=1`.
- Drain without accept (`out_valid && out_ready && !accept`): `out_valid<=0`. `out_data`/`out_err` hold their last values; they are don't-care when `out_valid`=0.
- FULL and `!out_ready`: all output fields are held stable. `in_ready`=0.
- `in_valid` with `!in_ready`: the input is not consumed. It must be held by the source per valid/ready rules; no check occurs and no counting.
- Status updates on accept of a bad word:
  - `err_pulse<=1`, otherwise `err_pulse<=0`.
  - `err_sticky<=1`.
  - `err_cnt<=err_cnt+1` unless all-ones, in which case it stays all-ones.
- `clr_err` alone: `err_cnt<=0`, `err_sticky<=0`.
- `clr_err` in the same cycle as a bad accept: the new event wins. `err_cnt<=1`, `err_sticky<=1`, `err_pulse<=1`.
- `clr_err` does not affect the data path.
- Words are counted whether or not `out_ready` is asserted later; errors are never dropped.

## Timing
- Latency: input accept at edge N, word visible on `out_*` after edge N, `err_pulse` high for the cycle after edge N.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Reset values (after the `rst` edge):
  - `out_valid`=0, `out_data`=0, `out_err`=0.
  - `err_pulse`=0, `err_cnt`=0, `err_sticky`=0.
  - `in_ready`=0 while `rst` is high, 1 on the first cycle after.
- Reset mid-operation: a held output word is discarded, and no accept occurs in the reset cycle.
- `rst` has priority over `clr_err` and over accept.
- No combinational path from `in_*` to `out_*`. The only combinational path is `out_ready` to `in_ready`.

## Test plan
- Reset, then stream 0x00/p0, 0xA5/p0, 0x01/p1, 0xFF/p0 with `out_ready`=1 and WIDTH=8, ODD=0 -> one word out per cycle, 1 cycle late, data identical, `out_err`=0 on all, `err_cnt`=0.
- Inject 0x01/p0 and 0x03/p1 among good words -> `out_err`=1 on exactly those 2 words, 2 single-cycle `err_pulse`s, `err_cnt`=2, `err_sticky`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0 after the first accept, output held stable, `err_cnt` unchanged. Releasing `out_ready` gives no loss and no duplication.
- Saturation with CNT_WIDTH=2: send 5 bad words -> `err_cnt` steps 1, 2, 3, 3, 3.
- `clr_err` alone -> `err_cnt`=0, `err_sticky`=0. `clr_err` coincident with a bad accept -> `err_cnt`=1, `err_sticky`=1.
- Assert `rst` while FULL and stalled -> next cycle `out_valid`=0, all status 0, `in_ready`=0 during reset. ODD=1 run: 0x01/p0 passes, 0x01/p1 fails.
